// File: rtl/hnf_rxrsp_link_ctrl_pkg.sv
// rtl/hnf_rxrsp_link_ctrl_pkg.sv - shared CHI link types and constants for the HN-F RXRSP channel
package hnf_rxrsp_link_ctrl_pkg;

  // Link-layer activation states of the receiver side
  typedef enum logic [1:0] {
    LINK_STOP       = 2'd0,
    LINK_ACTIVATE   = 2'd1,
    LINK_RUN        = 2'd2,
    LINK_DEACTIVATE = 2'd3
  } link_state_t;

  // LCrdReturn response opcode: hands a credit back, never stored
  localparam logic [5:0] RSP_LCRDRETURN = 6'h00;

  // Receive-buffer depth per HN-F response port
  localparam int num_credits_for_hn_rsp [1] = '{4};

endpackage

// File: rtl/hnf_rxrsp_link_ctrl_updown_cnt.sv
// rtl/hnf_rxrsp_link_ctrl_updown_cnt.sv - saturating up/down counter used for credit and queue accounting
module updown_cnt #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_W = W'(MAX);

  // Simultaneous inc and dec cancel; each direction clamps at its bound
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && (count != MAX_W)) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/hnf_rxrsp_link_ctrl.sv
// rtl/hnf_rxrsp_link_ctrl.sv - RXRSP link activation FSM with credit grant and position-queue accounting
module hnf_rxrsp_link_ctrl
  import hnf_rxrsp_link_ctrl_pkg::*;
#(
  parameter int NUM_CREDITS = num_credits_for_hn_rsp[0],
  parameter int CW          = $clog2(NUM_CREDITS + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          RXLINKACTIVEREQ,
  output logic          RXLINKACTIVEACK,
  input  logic          RXRSPFLITV,
  input  logic [5:0]    rxrsp_opcode,
  output logic          RXRSPLCRDV,
  output logic          rxrsp_enq,
  input  logic          rxrsp_deq,
  output logic [CW-1:0] credits_out,
  output logic [CW-1:0] occupancy,
  output logic          link_err
);

  localparam logic [CW:0] NUM_W = (CW + 1)'(NUM_CREDITS);

  link_state_t state, state_next;

  logic          consume;
  logic          flit_idle;
  logic          cred_dec;
  logic          occ_dec;
  logic          grant;
  logic [CW:0]   sum_next;

  // Flits are only accepted once the link is up; earlier ones are protocol errors
  assign consume   = RXRSPFLITV && ((state == LINK_RUN) || (state == LINK_DEACTIVATE));
  assign flit_idle = RXRSPFLITV && ((state == LINK_STOP) || (state == LINK_ACTIVATE));
  assign rxrsp_enq = consume && (rxrsp_opcode != RSP_LCRDRETURN);

  // Underflowing decrements are blocked so the counters hold their value
  assign cred_dec = consume && (credits_out != '0);
  assign occ_dec  = rxrsp_deq && (occupancy != '0);

  // Buffer commitment after this edge, before any new grant
  assign sum_next = {1'b0, credits_out} + {1'b0, occupancy}
                  + (CW + 1)'(rxrsp_enq) - (CW + 1)'(cred_dec) - (CW + 1)'(occ_dec);
  assign grant    = (state == LINK_RUN) && (sum_next < NUM_W);

  // Link state register
  always_ff @(posedge clock) begin
    if (reset) state <= LINK_STOP;
    else       state <= state_next;
  end

  // Next-state and acknowledge decode
  always_comb begin
    state_next      = state;
    RXLINKACTIVEACK = 1'b0;
    case (state)
      LINK_STOP: begin
        if (RXLINKACTIVEREQ) state_next = LINK_ACTIVATE;
      end
      LINK_ACTIVATE: begin
        RXLINKACTIVEACK = 1'b1;
        state_next      = LINK_RUN;
      end
      LINK_RUN: begin
        RXLINKACTIVEACK = 1'b1;
        if (!RXLINKACTIVEREQ) state_next = LINK_DEACTIVATE;
      end
      LINK_DEACTIVATE: begin
        RXLINKACTIVEACK = 1'b1;
        if (credits_out == '0) state_next = LINK_STOP;
      end
      default: state_next = LINK_STOP;
    endcase
  end

  // One credit grant per cycle at most, registered toward the transmitter
  always_ff @(posedge clock) begin
    if (reset) RXRSPLCRDV <= 1'b0;
    else       RXRSPLCRDV <= grant;
  end

  // Sticky protocol-error flag
  always_ff @(posedge clock) begin
    if (reset) begin
      link_err <= 1'b0;
    end else if (flit_idle || (consume && (credits_out == '0)) ||
                 (rxrsp_deq && (occupancy == '0))) begin
      link_err <= 1'b1;
    end
  end

  updown_cnt #(.MAX(NUM_CREDITS), .W(CW)) u_credit_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (grant),
    .dec   (cred_dec),
    .count (credits_out)
  );

  updown_cnt #(.MAX(NUM_CREDITS), .W(CW)) u_occ_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (rxrsp_enq),
    .dec   (occ_dec),
    .count (occupancy)
  );

endmodule

// File: tb/tb_hnf_rxrsp_link_ctrl.sv
// tb/tb_hnf_rxrsp_link_ctrl.sv - scoreboard bench for hnf_rxrsp_link_ctrl with directed vectors
module tb_hnf_rxrsp_link_ctrl;

  localparam int NC = 4;
  localparam int CW = 3;

  logic          clock;
  logic          reset;
  logic          req;
  logic          ack;
  logic          flitv;
  logic [5:0]    opcode;
  logic          lcrdv;
  logic          enq;
  logic          deq;
  logic [CW-1:0] credits;
  logic [CW-1:0] occ;
  logic          err;

  typedef struct {
    int idx;
    int ack;
    int lcrdv;
    int enq;
    int cred;
    int occ;
    int err;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks;
  int   n_fail;
  int   vec_idx;

  hnf_rxrsp_link_ctrl #(.NUM_CREDITS(NC), .CW(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .RXLINKACTIVEREQ (req),
    .RXLINKACTIVEACK (ack),
    .RXRSPFLITV      (flitv),
    .rxrsp_opcode    (opcode),
    .RXRSPLCRDV      (lcrdv),
    .rxrsp_enq       (enq),
    .rxrsp_deq       (deq),
    .credits_out     (credits),
    .occupancy       (occ),
    .link_err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void check(input string name, input int act, input int expv, input int idx);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s vector %0d: got %0d expected %0d", name, idx, act, expv);
    end
  endfunction

  // Monitor: compares every sampled output set against the oldest expectation
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ack",       int'(ack),     e.ack,   e.idx);
      check("lcrdv",     int'(lcrdv),   e.lcrdv, e.idx);
      check("enq",       int'(enq),     e.enq,   e.idx);
      check("credits",   int'(credits), e.cred,  e.idx);
      check("occupancy", int'(occ),     e.occ,   e.idx);
      check("link_err",  int'(err),     e.err,   e.idx);
    end
  end

  // Apply one cycle of inputs and queue the outputs expected during that cycle
  task automatic step(input logic r, input logic q, input logic v, input logic [5:0] op,
                      input logic d, input int e_ack, input int e_lcrdv, input int e_enq,
                      input int e_cred, input int e_occ, input int e_err);
    exp_t e;
    @(posedge clock);
    #1;
    reset  = r;
    req    = q;
    flitv  = v;
    opcode = op;
    deq    = d;
    e.idx = vec_idx; e.ack = e_ack; e.lcrdv = e_lcrdv; e.enq = e_enq;
    e.cred = e_cred; e.occ = e_occ; e.err = e_err;
    exp_q.push_back(e);
    vec_idx++;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vec_idx  = 0;
    reset = 1'b1; req = 1'b0; flitv = 1'b0; opcode = 6'h00; deq = 1'b0;
    repeat (2) @(posedge clock);

    //    rst  req  v    op     deq   ack lcr enq crd occ err
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  0,  0,  0,  0,  0,  0); // 0 reset state, STOP
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  1,  0,  0,  0,  0,  0); // 1 ACTIVATE
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  1,  0,  0,  0,  0,  0); // 2 RUN
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  1,  1,  0,  1,  0,  0); // 3 grant 1
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  1,  1,  0,  2,  0,  0); // 4 grant 2
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  1,  1,  0,  3,  0,  0); // 5 grant 3
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  1,  1,  0,  4,  0,  0); // 6 grant 4
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  1,  0,  0,  4,  0,  0); // 7 buffer fully credited
    step(1'b0,1'b1,1'b1,6'h04,1'b0,  1,  0,  1,  4,  0,  0); // 8 flit enq
    step(1'b0,1'b1,1'b1,6'h14,1'b0,  1,  0,  1,  3,  1,  0); // 9 flit enq
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  1,  0,  0,  2,  2,  0); // 10 no new credit
    step(1'b0,1'b1,1'b0,6'h00,1'b1,  1,  0,  0,  2,  2,  0); // 11 deq
    step(1'b0,1'b1,1'b0,6'h00,1'b1,  1,  1,  0,  3,  1,  0); // 12 deq, regrant
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  1,  1,  0,  4,  0,  0); // 13 regrant
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  1,  0,  0,  4,  0,  0); // 14 full again
    step(1'b0,1'b0,1'b0,6'h00,1'b0,  1,  0,  0,  4,  0,  0); // 15 drop REQ
    step(1'b0,1'b0,1'b1,6'h00,1'b0,  1,  0,  0,  4,  0,  0); // 16 LCrdReturn, no enq
    step(1'b0,1'b0,1'b1,6'h00,1'b0,  1,  0,  0,  3,  0,  0); // 17
    step(1'b0,1'b0,1'b1,6'h00,1'b0,  1,  0,  0,  2,  0,  0); // 18
    step(1'b0,1'b0,1'b1,6'h00,1'b0,  1,  0,  0,  1,  0,  0); // 19 fourth return
    step(1'b0,1'b0,1'b0,6'h00,1'b0,  1,  0,  0,  0,  0,  0); // 20 still DEACTIVATE
    step(1'b0,1'b0,1'b0,6'h00,1'b0,  0,  0,  0,  0,  0,  0); // 21 STOP
    step(1'b0,1'b0,1'b1,6'h04,1'b0,  0,  0,  0,  0,  0,  0); // 22 flit in STOP dropped
    step(1'b0,1'b0,1'b0,6'h00,1'b0,  0,  0,  0,  0,  0,  1); // 23 error flagged
    step(1'b1,1'b0,1'b0,6'h00,1'b0,  0,  0,  0,  0,  0,  1); // 24 error held until reset
    step(1'b0,1'b0,1'b0,6'h00,1'b1,  0,  0,  0,  0,  0,  0); // 25 cleared; deq while empty
    step(1'b0,1'b0,1'b0,6'h00,1'b0,  0,  0,  0,  0,  0,  1); // 26 underflow flagged, occ stays 0
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  0,  0,  0,  0,  0,  1); // 27 bring link up
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  1,  0,  0,  0,  0,  1); // 28 ACTIVATE
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  1,  0,  0,  0,  0,  1); // 29 RUN
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  1,  1,  0,  1,  0,  1); // 30
    step(1'b0,1'b1,1'b0,6'h00,1'b0,  1,  1,  0,  2,  0,  1); // 31
    step(1'b1,1'b1,1'b0,6'h00,1'b0,  1,  1,  0,  3,  0,  1); // 32 reset mid-RUN
    step(1'b0,1'b0,1'b0,6'h00,1'b0,  0,  0,  0,  0,  0,  0); // 33 all cleared

    begin
      int budget;
      budget = 0;
      while ((exp_q.size() > 0) && (budget < 20)) begin
        @(posedge clock);
        budget++;
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
